// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared widths, master ID type and the fixed master numbering
// used by the SDRAM arbiter and its ID FIFO.
package sdram_arb_pkg;
    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 32;

    typedef logic [2:0] master_id_t;

    localparam master_id_t MASTER_DCACHE = 3'd0;
    localparam master_id_t MASTER_ICACHE = 3'd1;
    localparam master_id_t MASTER_VIDEO  = 3'd2;
endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus interfaces of the SDRAM arbiter.
//   sdram_arb_req_if : flattened per-master request/return bus (master i owns slice i).
//                      modport master = requesters, modport slave = arbiter.
//   sdram_arb_mem_if : single controller port.
//                      modport master = arbiter, modport slave = SDRAM controller.
interface sdram_arb_req_if #(
    parameter int NUM_MASTERS = 3
);
    import sdram_arb_pkg::*;

    logic [NUM_MASTERS-1:0]              m_request;
    logic [NUM_MASTERS-1:0]              m_ready;
    logic [NUM_MASTERS*SDRAM_ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS-1:0]              m_write;
    logic [NUM_MASTERS-1:0]              m_burst;
    logic [NUM_MASTERS*4-1:0]            m_wstrb;
    logic [NUM_MASTERS*SDRAM_DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]              m_rvalid;
    logic [SDRAM_DATA_W-1:0]             m_rdata;
    logic [SDRAM_ADDR_W-1:0]             m_raddress;
    logic                                m_complete;

    modport master (
        output m_request, m_addr, m_write, m_burst, m_wstrb, m_wdata,
        input  m_ready, m_rvalid, m_rdata, m_raddress, m_complete
    );
    modport slave (
        input  m_request, m_addr, m_write, m_burst, m_wstrb, m_wdata,
        output m_ready, m_rvalid, m_rdata, m_raddress, m_complete
    );
endinterface

interface sdram_arb_mem_if;
    import sdram_arb_pkg::*;

    logic                    sdram_ready;
    logic                    sdram_request;
    logic [SDRAM_ADDR_W-1:0] sdram_addr;
    logic                    sdram_write;
    logic                    sdram_burst;
    logic [3:0]              sdram_wstrb;
    logic [SDRAM_DATA_W-1:0] sdram_wdata;
    logic                    sdram_rvalid;
    logic [SDRAM_DATA_W-1:0] sdram_rdata;
    logic [SDRAM_ADDR_W-1:0] sdram_raddress;
    logic                    sdram_complete;

    modport master (
        input  sdram_ready, sdram_rvalid, sdram_rdata, sdram_raddress, sdram_complete,
        output sdram_request, sdram_addr, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata
    );
    modport slave (
        output sdram_ready, sdram_rvalid, sdram_rdata, sdram_raddress, sdram_complete,
        input  sdram_request, sdram_addr, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata
    );
endinterface

// File: rtl/sdram_arb_idfifo.sv
// sdram_arb_idfifo: in-order FIFO of master IDs for outstanding reads.
// Ports: i_clk, i_rst_n (async active-low), i_push/i_push_id, i_pop,
//        o_full, o_empty, o_head (ID of the oldest outstanding read).
// Push while full and pop while empty are ignored. DEPTH must be a power of two.
module sdram_arb_idfifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  master_id_t i_push_id,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output master_id_t o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    master_id_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_id;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port among NUM_MASTERS requesters.
// Ports: clock, reset (async active-low), req (sdram_arb_req_if.slave, per-master
//        request/return bus), mem (sdram_arb_mem_if.master, controller port),
//        arb_error (sticky: read beat arrived with no outstanding read).
// A registered one-entry stage drives the controller; winners are picked
// round-robin; read beats are routed to the master at the head of an ID FIFO.
// Build option: define SDRAM_ARB_PRIORITY_EN to give master 0 (data cache)
// absolute priority, with the other masters round-robin among themselves.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ID_DEPTH    = 4
) (
    input  logic            clock,
    input  logic            reset,
    sdram_arb_req_if.slave  req,
    sdram_arb_mem_if.master mem,
    output logic            arb_error
);
    logic                    r_valid;
    logic [SDRAM_ADDR_W-1:0] r_addr;
    logic                    r_write;
    logic                    r_burst;
    logic [3:0]              r_wstrb;
    logic [SDRAM_DATA_W-1:0] r_wdata;
    master_id_t              r_rr_ptr;
    logic                    r_arb_error;

    logic       w_stage_free;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_grant;
    master_id_t w_win;
    master_id_t w_head;
    logic [7:0] w_elig;
    logic [7:0] w_rr_cand;
    logic [7:0] w_write_pad;

    assign w_stage_free = !r_valid || mem.sdram_ready;
    assign w_write_pad  = 8'(req.m_write);

    // Eligibility: reads additionally need a free ID slot (count before any pop).
    always_comb begin
        w_elig = 8'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_stage_free && req.m_request[i] && (req.m_write[i] || !w_fifo_full)) begin
                w_elig[i] = 1'b1;
            end else begin
                w_elig[i] = 1'b0;
            end
        end
    end

`ifdef SDRAM_ARB_PRIORITY_EN
    assign w_rr_cand = w_elig & 8'hFE;
`else
    assign w_rr_cand = w_elig;
`endif

    // Winner selection: scan from rr_ptr+1 backwards so the nearest candidate is written last.
    always_comb begin
        int         c;
        master_id_t v_c;
        c       = 0;
        v_c     = MASTER_DCACHE;
        w_grant = 1'b0;
        w_win   = MASTER_DCACHE;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            c = int'(r_rr_ptr) + k;
            if (c >= NUM_MASTERS) begin
                c = c - NUM_MASTERS;
            end else begin
                c = c;
            end
            v_c = master_id_t'(c);
            if (w_rr_cand[v_c]) begin
                w_grant = 1'b1;
                w_win   = v_c;
            end else begin
                w_grant = w_grant;
                w_win   = w_win;
            end
        end
`ifdef SDRAM_ARB_PRIORITY_EN
        if (w_elig[MASTER_DCACHE]) begin
            w_grant = 1'b1;
            w_win   = MASTER_DCACHE;
        end else begin
            w_grant = w_grant;
            w_win   = w_win;
        end
`endif
    end

    // One-hot ready to the winner and return routing to the FIFO head.
    always_comb begin
        req.m_ready  = '0;
        req.m_rvalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req.m_ready[i]  = w_grant && (w_win == master_id_t'(i));
            req.m_rvalid[i] = mem.sdram_rvalid && !w_fifo_empty && (w_head == master_id_t'(i));
        end
    end

    assign req.m_rdata    = mem.sdram_rdata;
    assign req.m_raddress = mem.sdram_raddress;
    assign req.m_complete = mem.sdram_complete;

    assign w_push = w_grant && !w_write_pad[w_win];
    assign w_pop  = mem.sdram_rvalid && mem.sdram_complete;

    sdram_arb_idfifo #(
        .DEPTH (ID_DEPTH)
    ) u_idfifo (
        .i_clk     (clock),
        .i_rst_n   (reset),
        .i_push    (w_push),
        .i_push_id (w_win),
        .i_pop     (w_pop),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_head    (w_head)
    );

    // Output stage: reloads whenever it is free; empties when nobody wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_burst <= 1'b0;
            r_wstrb <= 4'd0;
            r_wdata <= '0;
        end else if (w_stage_free) begin
            r_valid <= w_grant;
            if (w_grant) begin
                r_addr  <= req.m_addr[int'(w_win)*SDRAM_ADDR_W +: SDRAM_ADDR_W];
                r_write <= w_write_pad[w_win];
                r_burst <= req.m_burst[int'(w_win)];
                r_wstrb <= req.m_wstrb[int'(w_win)*4 +: 4];
                r_wdata <= req.m_wdata[int'(w_win)*SDRAM_DATA_W +: SDRAM_DATA_W];
            end
        end
    end

    // Round-robin pointer; in priority mode master 0 grants leave it untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= master_id_t'(NUM_MASTERS - 1);
`ifdef SDRAM_ARB_PRIORITY_EN
        end else if (w_grant && (w_win != MASTER_DCACHE)) begin
`else
        end else if (w_grant) begin
`endif
            r_rr_ptr <= w_win;
        end
    end

    // Sticky error: a read beat with nothing outstanding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_arb_error <= 1'b0;
        end else if (mem.sdram_rvalid && w_fifo_empty) begin
            r_arb_error <= 1'b1;
        end
    end

    assign mem.sdram_request = r_valid;
    assign mem.sdram_addr    = r_addr;
    assign mem.sdram_write   = r_write;
    assign mem.sdram_burst   = r_burst;
    assign mem.sdram_wstrb   = r_wstrb;
    assign mem.sdram_wdata   = r_wdata;
    assign arb_error         = r_arb_error;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter: requesters, a simple SDRAM controller and a
// transaction-level reference (queues for the ID FIFO and return stream, modular
// round-robin search) all live here; the DUT is compared every cycle.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int N        = 3;
    localparam int ID_DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic arb_error;

    sdram_arb_req_if #(.NUM_MASTERS(N)) u_req ();
    sdram_arb_mem_if                    u_mem ();

    sdram_arbiter #(
        .NUM_MASTERS (N),
        .ID_DEPTH    (ID_DEPTH)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .req       (u_req),
        .mem       (u_mem),
        .arb_error (arb_error)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // requester state: a pending request is held stable until granted
    bit          pend    [N];
    logic [25:0] p_addr  [N];
    bit          p_wr    [N];
    bit          p_burst [N];
    logic [3:0]  p_wstrb [N];
    logic [31:0] p_wdata [N];

    // reference model
    bit          mdl_sv;
    logic [25:0] mdl_addr;
    bit          mdl_wr;
    bit          mdl_burst;
    logic [3:0]  mdl_wstrb;
    logic [31:0] mdl_wdata;
    int          mdl_rr;
    int          idq[$];
    bit          mdl_err;

    // controller model: reads it has accepted and not fully returned
    int          ret_len[$];
    logic [25:0] ret_addr[$];
    int          cur_beat;

    int req_pct, wr_pct, rdy_pct, ret_pct;
    bit no_new;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input bit keep_inflight);
        reset = 1'b0;
        u_req.m_request      = '0;
        u_mem.sdram_ready    = 1'b0;
        u_mem.sdram_rvalid   = 1'b0;
        u_mem.sdram_complete = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        mdl_sv  = 1'b0;
        mdl_rr  = N - 1;
        mdl_err = 1'b0;
        idq.delete();
        if (!keep_inflight) begin
            ret_len.delete();
            ret_addr.delete();
            cur_beat = 0;
        end
        @(negedge clock);
        chk("rst_sdram_request", 64'(u_mem.sdram_request), 64'd0);
        chk("rst_sdram_addr",    64'(u_mem.sdram_addr),    64'd0);
        chk("rst_sdram_write",   64'(u_mem.sdram_write),   64'd0);
        chk("rst_sdram_burst",   64'(u_mem.sdram_burst),   64'd0);
        chk("rst_sdram_wstrb",   64'(u_mem.sdram_wstrb),   64'd0);
        chk("rst_sdram_wdata",   64'(u_mem.sdram_wdata),   64'd0);
        chk("rst_arb_error",     64'(arb_error),           64'd0);
        chk("rst_m_ready",       64'(u_req.m_ready),       64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic run_cycle(input bit spurious);
        bit          rdy, rv, cpl, beat_q, free, full;
        logic [31:0] rdata;
        logic [25:0] raddr;
        int          win, c;
        logic [N-1:0] exp_rdy, exp_rv;

        // drive requesters
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && !no_new && (int'($urandom_range(99)) < req_pct)) begin
                pend[i]    = 1'b1;
                p_addr[i]  = 26'($urandom);
                p_wr[i]    = (int'($urandom_range(99)) < wr_pct);
                p_burst[i] = 1'($urandom_range(1));
                p_wstrb[i] = 4'($urandom);
                p_wdata[i] = $urandom;
            end
            u_req.m_request[i]        = pend[i];
            u_req.m_addr[i*26 +: 26]  = p_addr[i];
            u_req.m_write[i]          = p_wr[i];
            u_req.m_burst[i]          = p_burst[i];
            u_req.m_wstrb[i*4 +: 4]   = p_wstrb[i];
            u_req.m_wdata[i*32 +: 32] = p_wdata[i];
        end

        // drive controller side
        rdy    = (int'($urandom_range(99)) < rdy_pct);
        rdata  = $urandom;
        raddr  = 26'($urandom);
        beat_q = 1'b0;
        rv     = 1'b0;
        cpl    = 1'b0;
        if (spurious) begin
            rv  = 1'b1;
            cpl = 1'b1;
        end else if (ret_len.size() > 0 && int'($urandom_range(99)) < ret_pct) begin
            beat_q = 1'b1;
            rv     = 1'b1;
            raddr  = ret_addr[0] + 26'(cur_beat);
            cpl    = (cur_beat == ret_len[0] - 1);
        end
        u_mem.sdram_ready    = rdy;
        u_mem.sdram_rvalid   = rv;
        u_mem.sdram_complete = cpl;
        u_mem.sdram_rdata    = rdata;
        u_mem.sdram_raddress = raddr;

        @(negedge clock);

        // expected arbitration
        free = !mdl_sv || rdy;
        full = (idq.size() >= ID_DEPTH);
        win  = -1;
`ifdef SDRAM_ARB_PRIORITY_EN
        if (free && pend[0] && (p_wr[0] || !full)) win = 0;
`endif
        for (int k = 1; k <= N; k++) begin
            c = (mdl_rr + k) % N;
`ifdef SDRAM_ARB_PRIORITY_EN
            if (c == 0) continue;
`endif
            if (win < 0 && free && pend[c] && (p_wr[c] || !full)) win = c;
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        exp_rv = '0;
        if (rv && idq.size() > 0) exp_rv[idq[0]] = 1'b1;

        chk("m_ready",       64'(u_req.m_ready),       64'(exp_rdy));
        chk("sdram_request", 64'(u_mem.sdram_request), 64'(mdl_sv));
        if (mdl_sv) begin
            chk("sdram_addr",  64'(u_mem.sdram_addr),  64'(mdl_addr));
            chk("sdram_write", 64'(u_mem.sdram_write), 64'(mdl_wr));
            chk("sdram_burst", 64'(u_mem.sdram_burst), 64'(mdl_burst));
            chk("sdram_wstrb", 64'(u_mem.sdram_wstrb), 64'(mdl_wstrb));
            chk("sdram_wdata", 64'(u_mem.sdram_wdata), 64'(mdl_wdata));
        end
        chk("m_rvalid",   64'(u_req.m_rvalid),   64'(exp_rv));
        chk("m_rdata",    64'(u_req.m_rdata),    64'(rdata));
        chk("m_raddress", 64'(u_req.m_raddress), 64'(raddr));
        chk("m_complete", 64'(u_req.m_complete), 64'(cpl));
        chk("arb_error",  64'(arb_error),        64'(mdl_err));

        // advance model to the next edge
        if (rv && idq.size() == 0) mdl_err = 1'b1;
        if (mdl_sv && rdy && !mdl_wr) begin
            ret_len.push_back(mdl_burst ? 16 : 1);
            ret_addr.push_back(mdl_addr);
        end
        if (beat_q) begin
            if (cpl) begin
                void'(ret_len.pop_front());
                void'(ret_addr.pop_front());
                cur_beat = 0;
            end else begin
                cur_beat++;
            end
        end
        if (rv && cpl && idq.size() > 0) void'(idq.pop_front());
        if (win >= 0) begin
            mdl_sv    = 1'b1;
            mdl_addr  = p_addr[win];
            mdl_wr    = p_wr[win];
            mdl_burst = p_burst[win];
            mdl_wstrb = p_wstrb[win];
            mdl_wdata = p_wdata[win];
            if (!p_wr[win]) idq.push_back(win);
`ifdef SDRAM_ARB_PRIORITY_EN
            if (win != 0) mdl_rr = win;
`else
            mdl_rr = win;
`endif
            pend[win] = 1'b0;
        end else if (free) begin
            mdl_sv = 1'b0;
        end

        @(posedge clock); #1;
    endtask

    task automatic set_mix(input int rq, input int wr, input int rd, input int rt, input bit nn);
        req_pct = rq;
        wr_pct  = wr;
        rdy_pct = rd;
        ret_pct = rt;
        no_new  = nn;
    endtask

    initial begin
        bit idle;
        u_req.m_request = '0;
        u_req.m_addr    = '0;
        u_req.m_write   = '0;
        u_req.m_burst   = '0;
        u_req.m_wstrb   = '0;
        u_req.m_wdata   = '0;
        u_mem.sdram_rdata    = '0;
        u_mem.sdram_raddress = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_addr[i] = '0; p_wr[i] = 1'b0;
            p_burst[i] = 1'b0; p_wstrb[i] = '0; p_wdata[i] = '0;
        end
        mdl_addr = '0; mdl_wr = 1'b0; mdl_burst = 1'b0; mdl_wstrb = '0; mdl_wdata = '0;
        cur_beat = 0;

        do_reset(1'b0);

        // all masters read every cycle after reset, no returns: first grants then FIFO full
        set_mix(100, 0, 100, 0, 1'b0);
        repeat (8) run_cycle(1'b0);

        // mixed traffic, moderate backpressure
        set_mix(60, 40, 70, 60, 1'b0);
        repeat (1500) run_cycle(1'b0);

        // heavy backpressure
        set_mix(70, 50, 20, 40, 1'b0);
        repeat (300) run_cycle(1'b0);

        // saturated requests, controller always ready
        set_mix(100, 50, 100, 70, 1'b0);
        repeat (300) run_cycle(1'b0);

        // drain everything
        set_mix(0, 0, 100, 100, 1'b1);
        idle = 1'b0;
        for (int t = 0; t < 800 && !idle; t++) begin
            idle = !mdl_sv && (idq.size() == 0) && (ret_len.size() == 0) && !pend[0] && !pend[1] && !pend[2];
            if (!idle) run_cycle(1'b0);
        end
        chk("drain_done", 64'(idle), 64'd1);

        // spurious beat with nothing outstanding; flag must stick
        run_cycle(1'b1);
        repeat (4) run_cycle(1'b0);
        chk("spurious_sticky", 64'(arb_error), 64'd1);

        // reset clears the flag
        do_reset(1'b0);

        // reads in flight, then reset: late beats must raise the flag
        set_mix(100, 0, 100, 0, 1'b0);
        repeat (10) run_cycle(1'b0);
        do_reset(1'b1);
        set_mix(0, 0, 100, 100, 1'b1);
        repeat (80) run_cycle(1'b0);
        chk("inflight_after_reset_err", 64'(arb_error), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

- Shares the single SDRAM controller port between up to NUM_MASTERS requesters: data cache, instruction-cache refill and video/blitter.
- Sits between those masters and the SDRAM controller, and uses the same request/ready/rvalid/complete protocol on both sides.
- Accepts one request per cycle through a registered one-entry output stage.
- Selects winners round-robin.
- Routes in-order read returns back to the issuing master through a master-ID FIFO.

## Interface
Parameters:
- NUM_MASTERS, 3, number of requesters (2..8); master 0 is the data cache
- ID_DEPTH, 4, outstanding reads tracked (power of two)

Ports (per-master buses are flattened; master i occupies slice i):
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low; 0 = reset
- m_request  input  NUM_MASTERS  master i presents a request
- m_ready  output  NUM_MASTERS  master i's request is accepted this cycle
- m_addr  input  26*NUM_MASTERS  request address
- m_write  input  NUM_MASTERS  0 = read, 1 = write
- m_burst  input  NUM_MASTERS  1 = 16-beat burst, 0 = single
- m_wstrb  input  4*NUM_MASTERS  write byte enables
- m_wdata  input  32*NUM_MASTERS  write data
- m_rvalid  output  NUM_MASTERS  read beat for master i
- m_rdata  output  32  read data, broadcast to all masters
- m_raddress  output  26  read beat address, broadcast
- m_complete  output  1  final beat of the read, broadcast
- sdram_ready  input  1  controller accepts a request
- sdram_request  output  1  request valid
- sdram_addr  output  26  request address
- sdram_write  output  1  read/write
- sdram_burst  output  1  burst
- sdram_wstrb  output  4  byte enables
- sdram_wdata  output  32  write data
- sdram_rvalid  input  1  read beat valid
- sdram_rdata  input  32  read data
- sdram_raddress  input  26  read beat address
- sdram_complete  input  1  final beat
- arb_error  output  1  sticky protocol-error flag

## Operation
- **Handshake:** a transfer occurs when m_request[i] and m_ready[i] are both 1.
  - m_ready may depend combinationally on m_request.
  - m_request must not depend on m_ready.
  - Masters hold request fields stable until accepted.
- **Output stage:** a one-entry register drives the sdram_* outputs.
  - The stage is free when it is empty, or when sdram_request and sdram_ready are both 1 this cycle.
- **Eligibility:** when the stage is free, master i is eligible if m_request[i] is 1 and either:
  - m_write[i] is 1, or
  - the ID FIFO is not full. The count is taken before any pop in the same cycle.
- **Winner selection:** round-robin among eligible masters, searching from rr_ptr+1 and wrapping modulo NUM_MASTERS.
- **On a grant to master w:**
  - m_ready[w] = 1, one-hot; all other m_ready bits are 0.
  - The stage loads w's fields.
  - rr_ptr becomes w.
  - For a read, w is pushed into the ID FIFO.
- **No grant:** if no master is eligible while the stage is being consumed, the stage goes empty and sdram_request falls to 0.
- **Read return:**
  - m_rvalid[head] = sdram_rvalid.
  - m_rdata, m_raddress and m_complete pass through unregistered.
  - The FIFO pops on sdram_rvalid and sdram_complete both 1.
  - A single read returns one beat with complete set.
- **Error:** sdram_rvalid while the FIFO is empty:
  - the beat is dropped and all m_rvalid stay 0;
  - arb_error is set and stays set until reset.
- **Writes:** produce no return and no FIFO entry.

## Timing
- Request accepted in cycle N appears on sdram_request in cycle N+1.
- Sustained throughput is 1 request per cycle when sdram_ready is held 1.
- Read-return path has zero latency; it is combinational from sdram_rvalid to m_rvalid.
- Reset values:
  - sdram_request = 0 and all sdram_* fields = 0;
  - stage empty, FIFO empty;
  - rr_ptr = NUM_MASTERS-1, so master 0 wins first;
  - m_ready = 0 while no master requests;
  - arb_error = 0.
- Reset asserted mid-burst clears the stage and the FIFO immediately. Beats still in flight after reset releases raise arb_error.
- FIFO full: reads stall and writes continue. A simultaneous pop and read request in the full state does not grant that read; it is granted the next cycle.
- Simultaneous push and pop when the FIFO is not full: count is unchanged.

## Configuration
- SDRAM_ARB_PRIORITY_EN defined:
  - master 0 (data cache) wins whenever it is eligible;
  - the remaining masters are round-robin among themselves;
  - rr_ptr updates only on grants to masters other than 0.
- Not defined: pure round-robin as described above.

## Structure
- Package sdram_arb_pkg contains:
  - SDRAM_ADDR_W = 26 and SDRAM_DATA_W = 32;
  - master_id_t, 3 bits;
  - MASTER_DCACHE = 0, MASTER_ICACHE = 1, MASTER_VIDEO = 2.
- Sub-module sdram_arb_idfifo: ID_DEPTH x master_id_t, with push/pop/full/empty/head and async active-low reset.
- Top level holds the eligibility logic, round-robin selection, output stage and return routing.

## Test plan
- **Reset first grant:** reset release, then masters 0, 1 and 2 request reads every cycle with sdram_ready = 1.
  - Grants go 0, 1, 2, 0 on consecutive cycles.
  - sdram_addr follows one cycle later.
- **Backpressure:** master 1 writes 0x100 with wstrb 0x3 while sdram_ready = 0 for 3 cycles.
  - sdram_request stays 1 with stable fields and m_ready stays 0.
  - When ready rises, the handshake completes and m_ready[1] pulses for the next request.
- **Read routing:** master 2 burst read, then master 0 single read.
  - 16 sdram_rvalid beats assert m_rvalid[2] only.
  - The following single beat with complete asserts m_rvalid[0].
- **FIFO full:** 4 reads outstanding, then master 0 requests a read and master 1 a write.
  - Only master 1 is granted.
  - After the complete beat pops, master 0 is granted the next cycle.
- **Spurious beat:** sdram_rvalid with the FIFO empty.
  - arb_error = 1 and m_rvalid = 0.
  - Flag clears only on reset.
- **SDRAM_ARB_PRIORITY_EN:** masters 0 and 1 request continuously.
  - Master 0 wins every cycle.
  - Master 1 is granted once master 0 drops its request.
